// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline sequencer for the 5-stage core.
//
// Each cycle it decides whether the pipeline freezes on a data-memory wait,
// flushes for a taken branch, or inserts a load-use bubble. It drives the
// per-stage write enables and flush requests for those cases. It also keeps
// saturating stall and flush statistics and a sticky memory-timeout flag.
//
// Ports
//   clk, rst                   clock (rising edge), async active-low reset
//   id_rs, id_rt               source register fields of the instruction in ID
//   id_uses_rs, id_uses_rt     ID instruction actually reads rs / rt
//   ex_Mread, ex_rt            EX holds a load, and the load's destination
//   mem_branch_taken           branch resolved taken in MEM
//   dmem_req, dmem_ready       MEM data access in progress / completes now
//   PC_Write .. MEMWB_Write    per-stage write enables (combinational)
//   IFID/IDEX/EXMEM_flush      clear that pipeline register at the next edge
//   state                      0=RUN, 1=MEMWAIT
//   stall_cnt, flush_cnt       saturating statistics
//   err_timeout                sticky: a memory wait lasted TIMEOUT cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_Mread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             MEMWB_Write,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic             state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             err_q, err_d;

    logic freeze;
    logic loaduse;
    logic stall_inc;
    logic flush_inc;

    // A request that drops mid-wait also counts as no freeze, so the FSM
    // releases on its own without a separate abort path.
    assign freeze  = dmem_req & ~dmem_ready;
    assign loaduse = ex_Mread & (ex_rt != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_rt)) |
                      (id_uses_rt & (id_rt == ex_rt)));

    // State register and statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next state and Mealy control outputs, in priority order
    always_comb begin
        state_d     = freeze ? MEMWAIT : RUN;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Write  = 1'b1;
        EXMEM_Write = 1'b1;
        MEMWB_Write = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (!rst) begin
            // Reset takes effect on the controls immediately, not at an edge.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            MEMWB_Write = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
        end else if (freeze) begin
            // Whole pipeline holds. A pending branch stays in EX/MEM and is
            // acted on in the release cycle.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            MEMWB_Write = 1'b0;
            stall_inc   = 1'b1;
        end else if (mem_branch_taken) begin
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (loaduse) begin
            // One bubble into EX. It clears ex_Mread, so the hazard drops
            // after a single cycle.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_flush  = 1'b1;
            stall_inc   = 1'b1;
        end

        wait_cnt_d  = freeze ? ((wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1)
                             : 8'd0;
        err_d       = err_q | (freeze & (wait_cnt_q == WAIT_LAST));
        stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int CNT_W = 2;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, ex_Mread, mem_branch_taken, dmem_req, dmem_ready;
  logic PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
  logic IFID_flush, IDEX_flush, EXMEM_flush, state, err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_Mread(ex_Mread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout)
  );

  // wr = {PC,IFID,IDEX,EXMEM,MEMWB}, fl = {IFID,IDEX,EXMEM}
  typedef struct {
    logic [4:0]       wr;
    logic [2:0]       fl;
    logic             st;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic             m_st;
  logic [7:0]       m_wait;
  logic [CNT_W-1:0] m_sc, m_fc;
  logic             m_err;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic mreset();
    m_st = 1'b0; m_wait = 8'd0; m_sc = '0; m_fc = '0; m_err = 1'b0;
  endtask

  // Apply one cycle of stimulus (called just after a falling edge).
  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr,
                       input logic [4:0] ert, input logic br, input logic req,
                       input logic rdy);
    logic fz, lu;
    exp_t e, o;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_Mread = mr; ex_rt = ert; mem_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    fz = req & ~rdy;
    lu = mr && ert != 0 && ((urs && rs == ert) || (urt && rt == ert));
    if (!r) mreset();
    if (!r)      begin e.wr = 5'b00000; e.fl = 3'b111; end
    else if (fz) begin e.wr = 5'b00000; e.fl = 3'b000; end
    else if (br) begin e.wr = 5'b11111; e.fl = 3'b111; end
    else if (lu) begin e.wr = 5'b00111; e.fl = 3'b010; end
    else         begin e.wr = 5'b11111; e.fl = 3'b000; end
    e.st = m_st; e.sc = m_sc; e.fc = m_fc; e.err = m_err;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk("writes", {3'b0, PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write}, {3'b0, o.wr});
    chk("flushes", {5'b0, IFID_flush, IDEX_flush, EXMEM_flush}, {5'b0, o.fl});
    chk("state", {7'b0, state}, {7'b0, o.st});
    chk("stall_cnt", 8'(stall_cnt), 8'(o.sc));
    chk("flush_cnt", 8'(flush_cnt), 8'(o.fc));
    chk("err_timeout", {7'b0, err_timeout}, {7'b0, o.err});
    @(posedge clk);
    if (!r) mreset();
    else begin
      if (fz && m_wait == 8'(TMO - 1)) m_err = 1'b1;
      m_wait = fz ? ((m_wait == 8'hFF) ? m_wait : m_wait + 8'd1) : 8'd0;
      m_st = fz;
      if ((fz || (!br && lu)) && m_sc != '1) m_sc = m_sc + 1'b1;
      if (!fz && br && m_fc != '1) m_fc = m_fc + 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic freeze(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mreset();
    rst = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_Mread = 0; ex_rt = 0; mem_branch_taken = 0; dmem_req = 1; dmem_ready = 0;
    @(negedge clk);
    // reset held with freeze and branch inputs active
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 8, 8, 1, 1, 1, 8, 0, 1, 0);
    idle(2);
    // load-use via rs, then rt; ex_rt=0 and unused-field matches do not stall
    drive(1, 8, 0, 1, 0, 1, 8, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 3, 8, 0, 1, 1, 8, 0, 0, 0);
    drive(1, 8, 8, 0, 0, 1, 8, 0, 0, 0);
    drive(1, 8, 0, 1, 0, 0, 8, 0, 0, 0);
    idle(1);
    // branch together with load-use: branch wins, stall not counted
    drive(1, 8, 0, 1, 0, 1, 8, 1, 0, 0);
    idle(1);
    // branch during freeze is held, then taken on release
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    // memory wait of 3 cycles then ready
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    freeze(3);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // request dropping mid-wait releases
    freeze(2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // timeout: 6 freeze cycles, sticky after release
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    freeze(3);
    freeze(3);
    idle(2);
    // async reset mid-wait clears state and error without a clock edge
    freeze(2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // 3 freezes do not trip the timeout after a break
    freeze(3);
    idle(1);
    freeze(3);
    idle(1);
    // stall counter saturation
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 5, 0, 1, 0, 1, 5, 0, 0, 0);
    idle(1);
    // flush counter saturation
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // random mix with a small register range to hit matches often
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      drive(($urandom_range(0, 39) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
